// File: rtl/xm_isa_pkg.sv
// rtl/xm_isa_pkg.sv - shared MOV-group ISA definitions for the immediate encoder/decoder
//
// Purpose: instruction field layout, MOV-group type encoding and encoder FSM
//          state type. The immediate decoder imports this same package, so
//          field positions must only ever change here.
// Ports:   none (package)
// Word layout: {MOV_PREFIX[15:13], type[12:11], byte[10:3], dst[2:0]}

package xm_isa_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] MOV_PREFIX = 3'b011;

  localparam int TYPE_H = 12;
  localparam int TYPE_L = 11;
  localparam int IMM_H  = 10;
  localparam int IMM_L  = 3;
  localparam int DST_H  = 2;
  localparam int DST_L  = 0;

  typedef enum logic [1:0] {
    MOVL  = 2'd0,
    MOVLZ = 2'd1,
    MOVLS = 2'd2,
    MOVH  = 2'd3
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } enc_state_e;

endpackage

// File: rtl/imm_word_pack.sv
// rtl/imm_word_pack.sv - combinational packer for one MOV-group instruction word
//
// Purpose: assembles {prefix, type, byte, dst} into a 16-bit instruction word.
// Ports:
//   imm_type  in   2  MOV-group type (MOVL/MOVLZ/MOVLS/MOVH)
//   imm_byte  in   8  immediate byte
//   dst       in   3  destination register
//   word      out 16  packed instruction word

module imm_word_pack
  import xm_isa_pkg::*;
(
  input  imm_type_e          imm_type,
  input  logic [7:0]         imm_byte,
  input  logic [DST_H:DST_L] dst,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word                  = '0;
    word[15:13]           = MOV_PREFIX;
    word[TYPE_H:TYPE_L]   = imm_type;
    word[IMM_H:IMM_L]     = imm_byte;
    word[DST_H:DST_L]     = dst;
  end

endmodule

// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - encodes a 16-bit constant into the shortest MOV-group load sequence
//
// Purpose: accepts {constant, destination} requests and emits one or two
//          registered instruction words for the debug/boot injection path.
// Optional feature: IMM_ENC_SHORT_EN
//   defined   - constants with hi byte 0x00 / 0xFF use a single MOVLZ / MOVLS word
//   undefined - every constant emits MOVLZ lo, MOVH hi (fixed two-word sequences)
// Ports:
//   clk_i        in   1         clock
//   rstn_i       in   1         synchronous active-low reset
//   flush_i      in   1         synchronous abort of any sequence in progress
//   immVal_i     in   WORD      constant to encode
//   dstReg_i     in   REG_BITS  destination register
//   reqValid_i   in   1         request valid
//   reqReady_o   out  1         request accepted when reqValid_i & reqReady_o
//   instWord_o   out  WORD      emitted instruction word
//   instValid_o  out  1         instWord_o valid
//   instReady_i  in   1         consumer accepts the word
//   instLast_o   out  1         final word of the sequence
//   seqLen_o     out  2         word count of current sequence, 0 when idle

module immediate_encoder
  import xm_isa_pkg::*;
#(
  parameter int WORD     = 16,  // only 16 is supported
  parameter int REG_BITS = 3
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                flush_i,
  input  logic [WORD-1:0]     immVal_i,
  input  logic [REG_BITS-1:0] dstReg_i,
  input  logic                reqValid_i,
  output logic                reqReady_o,
  output logic [WORD-1:0]     instWord_o,
  output logic                instValid_o,
  input  logic                instReady_i,
  output logic                instLast_o,
  output logic [1:0]          seqLen_o
);

  enc_state_e          state_q, state_d;
  logic [WORD-1:0]     word_q, word_d;
  logic                last_q, last_d;
  logic [1:0]          len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [REG_BITS-1:0] dst_q, dst_d;

  logic                accept;
  logic                use_second;
  imm_type_e           first_type;
  logic [1:0]          first_len;
  imm_type_e           pack_type;
  logic [7:0]          pack_byte;
  logic [REG_BITS-1:0] pack_dst;
  logic [WORD-1:0]     pack_word;

  assign instValid_o = (state_q != ST_IDLE);
  assign instWord_o  = word_q;
  assign instLast_o  = last_q;
  assign seqLen_o    = len_q;

  // Ready also opens during the final-word handshake so a new sequence can
  // follow with no bubble. Reset and flush both close it.
  assign reqReady_o = rstn_i & ~flush_i &
                      ((state_q == ST_IDLE) | (instValid_o & instLast_o & instReady_i));
  assign accept     = reqValid_i & reqReady_o;

  // Classify the incoming constant into the first word type and sequence length.
  always_comb begin
    first_type = MOVLZ;
    first_len  = 2'd2;
`ifdef IMM_ENC_SHORT_EN
    if (immVal_i[15:8] == 8'h00) begin
      first_type = MOVLZ;
      first_len  = 2'd1;
    end else if (immVal_i[15:8] == 8'hFF) begin
      first_type = MOVLS;
      first_len  = 2'd1;
    end
`endif
  end

  // A single packer serves both words. The MOVH word is only ever needed while
  // leaving FIRST of a two-word sequence; no request can be accepted then
  // because the first word is not last, so the mux never has a conflict.
  assign use_second = (state_q == ST_FIRST) && (len_q == 2'd2);
  assign pack_type  = use_second ? MOVH : first_type;
  assign pack_byte  = use_second ? hi_q : immVal_i[7:0];
  assign pack_dst   = use_second ? dst_q : dstReg_i;

  imm_word_pack u_pack (
    .imm_type (pack_type),
    .imm_byte (pack_byte),
    .dst      (pack_dst),
    .word     (pack_word)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    len_d   = len_q;
    hi_d    = hi_q;
    dst_d   = dst_q;

    case (state_q)
      ST_IDLE: begin
      end
      ST_FIRST: begin
        if (instReady_i) begin
          if (len_q == 2'd2) begin
            state_d = ST_SECOND;
            word_d  = pack_word;
            last_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            word_d  = '0;
            last_d  = 1'b0;
            len_d   = 2'd0;
          end
        end
      end
      ST_SECOND: begin
        if (instReady_i) begin
          state_d = ST_IDLE;
          word_d  = '0;
          last_d  = 1'b0;
          len_d   = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
        last_d  = 1'b0;
        len_d   = 2'd0;
      end
    endcase

    // Acceptance overrides the drain-to-idle above (back-to-back re-entry).
    if (accept) begin
      state_d = ST_FIRST;
      word_d  = pack_word;
      last_d  = (first_len == 2'd1);
      len_d   = first_len;
      hi_d    = immVal_i[15:8];
      dst_d   = dstReg_i;
    end

    if (flush_i) begin
      state_d = ST_IDLE;
      word_d  = '0;
      last_d  = 1'b0;
      len_d   = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      len_q   <= 2'd0;
      hi_q    <= 8'h00;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      dst_q   <= dst_d;
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// tb/tb_immediate_encoder.sv - table-driven self-checking bench for immediate_encoder

module tb_immediate_encoder;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic [15:0] immVal_i;
  logic [2:0]  dstReg_i;
  logic        reqValid_i;
  logic        reqReady_o;
  logic [15:0] instWord_o;
  logic        instValid_o;
  logic        instReady_i;
  logic        instLast_o;
  logic [1:0]  seqLen_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  immediate_encoder dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .immVal_i    (immVal_i),
    .dstReg_i    (dstReg_i),
    .reqValid_i  (reqValid_i),
    .reqReady_o  (reqReady_o),
    .instWord_o  (instWord_o),
    .instValid_o (instValid_o),
    .instReady_i (instReady_i),
    .instLast_o  (instLast_o),
    .seqLen_o    (seqLen_o)
  );

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  dst;
    logic [1:0]  s_len;  // length with short forms enabled
    logic [15:0] s_w0;   // first word with short forms enabled
    logic [15:0] l_w0;   // first word, fixed two-word build
    logic [15:0] l_w1;   // MOVH word
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input logic last, input logic [1:0] len);
    chk({tag, " valid"}, 16'(instValid_o), 16'd1);
    chk({tag, " word"},  instWord_o, w);
    chk({tag, " last"},  16'(instLast_o), 16'(last));
    chk({tag, " len"},   16'(seqLen_o), 16'(len));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " valid"}, 16'(instValid_o), 16'd0);
    chk({tag, " word"},  instWord_o, 16'h0000);
    chk({tag, " last"},  16'(instLast_o), 16'd0);
    chk({tag, " len"},   16'(seqLen_o), 16'd0);
  endtask

  task automatic run_seq(input string tag, input logic [15:0] imm, input logic [2:0] dst,
                         input logic [1:0] len, input logic [15:0] w0, input logic [15:0] w1);
    tick();
    reqValid_i = 1'b1; immVal_i = imm; dstReg_i = dst; instReady_i = 1'b1;
    #1;
    chk({tag, " req_ready"}, 16'(reqReady_o), 16'd1);
    tick();
    reqValid_i = 1'b0;
    #1;
    check_word({tag, " w0"}, w0, len == 2'd1, len);
    if (len == 2'd2) begin
      tick();
      #1;
      check_word({tag, " w1"}, w1, 1'b1, 2'd2);
    end
    tick();
    #1;
    check_idle({tag, " end"});
  endtask

  initial begin
    logic [1:0]  e_len;
    logic [15:0] e_w0;

    vecs[0] = '{16'h0042, 3'd3, 2'd1, 16'h6A13, 16'h6A13, 16'h7803};
    vecs[1] = '{16'hFF80, 3'd0, 2'd1, 16'h7400, 16'h6C00, 16'h7FF8};
    vecs[2] = '{16'h1234, 3'd7, 2'd2, 16'h69A7, 16'h69A7, 16'h7897};
    vecs[3] = '{16'h0001, 3'd1, 2'd1, 16'h6809, 16'h6809, 16'h7801};
    vecs[4] = '{16'hFFFF, 3'd5, 2'd1, 16'h77FD, 16'h6FFD, 16'h7FFD};
    vecs[5] = '{16'h0100, 3'd2, 2'd2, 16'h6802, 16'h6802, 16'h780A};
    vecs[6] = '{16'hFE00, 3'd6, 2'd2, 16'h6806, 16'h6806, 16'h7FF6};
    vecs[7] = '{16'h0000, 3'd0, 2'd1, 16'h6800, 16'h6800, 16'h7800};

    rstn_i = 1'b0; flush_i = 1'b0; immVal_i = '0; dstReg_i = '0;
    reqValid_i = 1'b0; instReady_i = 1'b0;

    repeat (2) tick();
    #1;
    check_idle("reset");
    chk("reset req_ready", 16'(reqReady_o), 16'd0);
    rstn_i = 1'b1;
    #1;
    chk("release req_ready", 16'(reqReady_o), 16'd1);

    for (int i = 0; i < 8; i++) begin
`ifdef IMM_ENC_SHORT_EN
      e_len = vecs[i].s_len;
      e_w0  = vecs[i].s_w0;
`else
      e_len = 2'd2;
      e_w0  = vecs[i].l_w0;
`endif
      run_seq($sformatf("vec%0d", i), vecs[i].imm, vecs[i].dst, e_len, e_w0, vecs[i].l_w1);
    end

    // Backpressure on the first word, then a back-to-back request on the last word.
    tick();
    reqValid_i = 1'b1; immVal_i = 16'h1234; dstReg_i = 3'd7; instReady_i = 1'b0;
    tick();
    reqValid_i = 1'b0;
    #1;
    check_word("bp w0", 16'h69A7, 1'b0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check_word($sformatf("bp hold%0d", k), 16'h69A7, 1'b0, 2'd2);
      chk($sformatf("bp hold%0d req_ready", k), 16'(reqReady_o), 16'd0);
    end
    instReady_i = 1'b1;
    tick();
    #1;
    check_word("bp w1", 16'h7897, 1'b1, 2'd2);
    reqValid_i = 1'b1; immVal_i = 16'h0001; dstReg_i = 3'd1;
    #1;
    chk("b2b req_ready", 16'(reqReady_o), 16'd1);
    tick();
    reqValid_i = 1'b0;
    #1;
`ifdef IMM_ENC_SHORT_EN
    check_word("b2b w0", 16'h6809, 1'b1, 2'd1);
`else
    check_word("b2b w0", 16'h6809, 1'b0, 2'd2);
    tick();
    #1;
    check_word("b2b w1", 16'h7801, 1'b1, 2'd2);
`endif
    tick();
    #1;
    check_idle("b2b end");

    // Flush while the MOVH word is pending; flush beats the handshake and a new request.
    reqValid_i = 1'b1; immVal_i = 16'h1234; dstReg_i = 3'd7; instReady_i = 1'b1;
    tick();
    reqValid_i = 1'b0;
    tick();
    #1;
    check_word("fl pend", 16'h7897, 1'b1, 2'd2);
    flush_i = 1'b1; reqValid_i = 1'b1; immVal_i = 16'h0042; dstReg_i = 3'd3;
    #1;
    chk("fl req_ready", 16'(reqReady_o), 16'd0);
    tick();
    flush_i = 1'b0; reqValid_i = 1'b0;
    #1;
    check_idle("fl after");
`ifdef IMM_ENC_SHORT_EN
    run_seq("fl next", 16'h0042, 3'd3, 2'd1, 16'h6A13, 16'h7803);
`else
    run_seq("fl next", 16'h0042, 3'd3, 2'd2, 16'h6A13, 16'h7803);
`endif

    // Reset while the MOVH word is pending.
    reqValid_i = 1'b1; immVal_i = 16'h1234; dstReg_i = 3'd7; instReady_i = 1'b1;
    tick();
    reqValid_i = 1'b0;
    tick();
    #1;
    check_word("rs pend", 16'h7897, 1'b1, 2'd2);
    rstn_i = 1'b0; instReady_i = 1'b0;
    #1;
    chk("rs req_ready", 16'(reqReady_o), 16'd0);
    tick();
    #1;
    check_idle("rs after");
    rstn_i = 1'b1;
    #1;
    chk("rs release req_ready", 16'(reqReady_o), 16'd1);
`ifdef IMM_ENC_SHORT_EN
    run_seq("rs next", 16'hFF80, 3'd0, 2'd1, 16'h7400, 16'h7FF8);
`else
    run_seq("rs next", 16'hFF80, 3'd0, 2'd2, 16'h6C00, 16'h7FF8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
